// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - nibble-serial adder: one 4-bit ripple slice reused NIBBLES times per operation
// Accepts one operand pair in IDLE, ripples LSB nibble first through RUN, holds the result in DONE.

module adder_seq_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_seq_rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;
  assign co   = c[4];

  for (genvar i = 0; i < 4; i++) begin : g_fa
    adder_seq_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end
endmodule

module adder_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 busy
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  logic [1:0]    state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic [IW-1:0] idx;
  logic          carry;
  logic          cout_q;
  logic          out_valid_q;

  logic [3:0]    a_sl;
  logic [3:0]    b_sl;
  logic [3:0]    s_sl;
  logic          c_sl;

  // {idx,2'b00} is idx*4, the bit offset of the active nibble
  assign a_sl = a_q[{idx, 2'b00} +: 4];
  assign b_sl = b_q[{idx, 2'b00} +: 4];

  adder_seq_rca4 u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .ci (carry),
    .s  (s_sl),
    .co (c_sl)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx         <= '0;
      carry       <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
            sum_q <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[{idx, 2'b00} +: 4] <= s_sl;
          carry                    <= c_sl;
          if (idx == LAST_IDX) begin
            idx         <= '0;
            cout_q      <= c_sl;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // retiring edge goes to IDLE only, so a new operand waits one more cycle
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN) || (state == DONE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb/tb_adder_seq_ctrl.sv - scoreboard bench for adder_seq_ctrl at NIBBLES=4 and NIBBLES=8
// A transaction-level model predicts handshakes and results; checks happen on the falling edge.

module tb_adder_seq_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done_flag [2];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic void note_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out waiting for DUT", name);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int N = (g == 0) ? 4 : 8;
    localparam int W = 4 * N;

    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         cin       = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic         cout;
    logic         busy;
    logic [W-1:0] sum;

    int cyc     = 0;
    int retired = 0;

    always @(posedge clk) cyc <= cyc + 1;

    adder_seq_ctrl #(.NIBBLES(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
    );

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + (W + 1)'(c);
    endfunction

    function automatic logic [W-1:0] rnd_op();
      case ($urandom % 6)
        0:       return '0;
        1:       return '1;
        default: return W'({$urandom, $urandom});
      endcase
    endfunction

    // model: one operation outstanding at a time, result visible N edges after accept
    logic [W:0] expq [$];
    int  ost     = 0;
    int  rdy_cyc = 0;
    bit  live    = 0;

    always @(negedge clk) begin
      if (live) begin
        chk($sformatf("n%0d in_ready", N), 64'(in_ready), 64'(ost == 0));
        chk($sformatf("n%0d busy", N), 64'(busy), 64'(ost != 0));
        chk($sformatf("n%0d out_valid", N), 64'(out_valid), 64'(ost != 0 && cyc >= rdy_cyc));
        if (ost != 0 && cyc >= rdy_cyc && expq.size() > 0)
          chk($sformatf("n%0d result", N), 64'({cout, sum}), 64'(expq[0]));
      end
      if (!rst_n) begin
        ost = 0;
        expq.delete();
        live = 1;
      end else if (live) begin
        if (ost == 0 && in_valid) begin
          expq.push_back(ref_add(a, b, cin));
          ost     = 1;
          rdy_cyc = cyc + 1 + N;
        end else if (ost != 0 && cyc >= rdy_cyc && out_ready) begin
          void'(expq.pop_front());
          ost = 0;
          retired++;
        end
      end
    end

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                      input int stall, input bit hold, input logic [W:0] req);
      int t;
      t = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (in_ready !== 1'b1 && t < 40) begin
        step();
        t++;
      end
      if (t >= 40) note_timeout($sformatf("n%0d idle_wait", N));
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = x;
      b         = y;
      cin       = c;
      step();
      if (!hold) in_valid = 1'b0;
      t = 0;
      while (out_valid !== 1'b1 && t < N + 4) begin
        if (hold) begin
          a   = rnd_op();
          b   = rnd_op();
          cin = 1'($urandom);
        end
        step();
        t++;
      end
      if (t >= N + 4) note_timeout($sformatf("n%0d out_valid_wait", N));
      chk($sformatf("n%0d directed", N), 64'({cout, sum}), 64'(req));
      repeat (stall) begin
        if (hold) begin
          a = rnd_op();
          b = rnd_op();
        end
        step();
      end
      out_ready = 1'b1;
      step();
      if (hold) step();
      in_valid = 1'b0;
    endtask

    initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W-1:0] msb;
      msb = '0;
      msb[W-1] = 1'b1;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      op(W'('h1234), W'('h4321), 1'b0, 0, 1'b0, (W + 1)'('h5555));
      op('1, '0, 1'b1, 0, 1'b0, {1'b1, {W{1'b0}}});
      op(msb, msb, 1'b0, 5, 1'b0, {1'b1, {W{1'b0}}});
      ra = rnd_op();
      rb = rnd_op();
      op(ra, rb, 1'b1, 2, 1'b1, ref_add(ra, rb, 1'b1));

      // abort an operation with a one-cycle reset during its second RUN cycle
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (N + 4) step();
      in_valid = 1'b1;
      a        = W'('h00FF);
      b        = W'('h0001);
      cin      = 1'b0;
      step();
      in_valid = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      op(W'('h0001), W'('h0001), 1'b0, 0, 1'b0, (W + 1)'('h0002));

      repeat (1500) begin
        in_valid  = 1'($urandom % 2);
        a         = rnd_op();
        b         = rnd_op();
        cin       = 1'($urandom);
        out_ready = (($urandom % 3) != 0);
        step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (N + 4) step();
      chk($sformatf("n%0d progress", N), 64'(retired >= 40), 64'd1);
      chk($sformatf("n%0d drained", N), 64'(expq.size()), 64'd0);
      done_flag[g] = 1'b1;
    end
  end

  initial begin
    wait (done_flag[0] && done_flag[1]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    note_timeout("global_watchdog");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
